// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Multi-cycle multiply/divide unit with HI/LO registers for the
//                EX stage. Supports MULT/DIV (signed and unsigned), MADD/MSUB
//                accumulation, same-cycle kill, in-flight abort and MTHI/MTLO.
//                Results commit exactly LAT edges after the accepting edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter bit MADD_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    input  logic             abort,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_max_lat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_cnt_w   = $clog2(c_max_lat + 1);

    localparam logic [c_cnt_w-1:0] c_mult_cnt = c_cnt_w'(MULT_LAT);
    localparam logic [c_cnt_w-1:0] c_div_cnt  = c_cnt_w'(DIV_LAT);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               w_commit;
    logic               w_accept;

    logic [WIDTH-1:0]   r_a, r_b;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_hi, r_lo;

    // Multiply / accumulate datapath signals
    logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod, w_hilo, w_mac;
    // Divide datapath signals
    logic               w_is_div, w_a_neg, w_b_neg, w_div_ok;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_q, w_r;

    // Ops 4-7 are only accepted when the accumulate modes are built in
    assign w_accept = start & ~kill & ~abort & (r_cnt == c_cnt_zero) & (MADD_EN | ~op[2]);
    assign busy     = w_accept | (r_cnt != c_cnt_zero);
    assign hi       = r_hi;
    assign lo       = r_lo;

    // State and countdown register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= c_cnt_zero;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: load latency on accept, count down, commit on 1->0 unless aborted
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = (op[2:1] == 2'b01) ? c_div_cnt : c_mult_cnt;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = c_cnt_zero;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = c_cnt_zero;
            end
        endcase
    end

    // Operand capture at accept; later a/b changes do not affect the op
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= 3'd0;
        end else if (w_accept) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= op;
        end
    end

    // Multiply: op[0]=0 selects signed; 2*WIDTH product wraps naturally
    always_comb begin
        w_ext_a = r_op[0] ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
        w_ext_b = r_op[0] ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
        w_prod  = w_ext_a * w_ext_b;
        w_hilo  = {r_hi, r_lo};
        if (!r_op[2]) begin
            w_mac = w_prod;
        end else if (r_op[1]) begin
            w_mac = w_hilo - w_prod;
        end else begin
            w_mac = w_hilo + w_prod;
        end
    end

    // Divide on magnitudes; MIN/-1 falls out as quotient MIN, remainder 0
    always_comb begin
        w_is_div = (r_op[2:1] == 2'b01);
        w_div_ok = (r_b != '0);
        w_a_neg  = ~r_op[0] & r_a[WIDTH-1];
        w_b_neg  = ~r_op[0] & r_b[WIDTH-1];
        w_a_mag  = w_a_neg ? (~r_a + 1'b1) : r_a;
        w_b_mag  = w_b_neg ? (~r_b + 1'b1) : r_b;
        w_q_mag  = w_div_ok ? (w_a_mag / w_b_mag) : '0;
        w_r_mag  = w_div_ok ? (w_a_mag % w_b_mag) : '0;
        w_q      = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
        w_r      = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;
    end

    // HI/LO: commit results, or take MTHI/MTLO only when idle and not accepting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            if (w_is_div) begin
                if (w_div_ok) begin
                    r_hi <= w_r;
                    r_lo <= w_q;
                end
            end else begin
                r_hi <= w_mac[2*WIDTH-1:WIDTH];
                r_lo <= w_mac[WIDTH-1:0];
            end
        end else if ((r_cnt == c_cnt_zero) && !w_accept) begin
            if (wr_hi) r_hi <= wdata;
            if (wr_lo) r_lo <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit. A 32-bit instance
//                (5/10 cycle latency) and a 16-bit instance (1/3 cycle
//                latency) share stimulus; sel chooses which one is driven.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        start = 1'b0, kill = 1'b0, abort = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0, wdata = '0;

    logic        busy32, busy16;
    logic [31:0] hi32, lo32;
    logic [15:0] hi16, lo16;
    logic        busy_cur;
    logic [31:0] hi_cur, lo_cur;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_hi[2];
    logic [31:0] m_lo[2];

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10), .MADD_EN(1'b1)) u_dut32 (
        .clk(clk), .reset(reset), .start(start & ~sel), .op(op), .a(a), .b(b),
        .kill(kill & ~sel), .abort(abort & ~sel), .wr_hi(wr_hi & ~sel), .wr_lo(wr_lo & ~sel),
        .wdata(wdata), .busy(busy32), .hi(hi32), .lo(lo32)
    );

    mult_div_unit #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(3), .MADD_EN(1'b1)) u_dut16 (
        .clk(clk), .reset(reset), .start(start & sel), .op(op), .a(a[15:0]), .b(b[15:0]),
        .kill(kill & sel), .abort(abort & sel), .wr_hi(wr_hi & sel), .wr_lo(wr_lo & sel),
        .wdata(wdata[15:0]), .busy(busy16), .hi(hi16), .lo(lo16)
    );

    assign busy_cur = sel ? busy16 : busy32;
    assign hi_cur   = sel ? {16'h0, hi16} : hi32;
    assign lo_cur   = sel ? {16'h0, lo16} : lo32;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (sel=%0d t=%0t)", nm, act, exp, sel, $time);
        end
    endtask

    function automatic int lat_of(input logic s, input logic [2:0] o);
        if (o[2:1] == 2'b01) return s ? 3 : 10;
        return s ? 1 : 5;
    endfunction

    // Reference: arithmetic on plain 64-bit integers, result {hi,lo} masked to width
    function automatic logic [63:0] ref_op(input logic s, input logic [2:0] o,
                                           input logic [31:0] xa, input logic [31:0] xb,
                                           input logic [31:0] h, input logic [31:0] l);
        int          w;
        logic [63:0] m, ua, ub, hl, p, r, q, rm;
        longint      sa, sb;
        bit          sg;
        w  = s ? 16 : 32;
        m  = s ? 64'hFFFF : 64'hFFFF_FFFF;
        ua = {32'b0, xa} & m;
        ub = {32'b0, xb} & m;
        sa = s ? longint'($signed(xa[15:0])) : longint'($signed(xa));
        sb = s ? longint'($signed(xb[15:0])) : longint'($signed(xb));
        sg = ~o[0];
        hl = (({32'b0, h} & m) << w) | ({32'b0, l} & m);
        if (o[2:1] == 2'b01) begin
            if (ub == 64'd0) return {h, l};
            q  = sg ? 64'(sa / sb) : ua / ub;
            rm = sg ? 64'(sa % sb) : ua % ub;
            return {rm[31:0] & m[31:0], q[31:0] & m[31:0]};
        end
        p = sg ? 64'(sa * sb) : ua * ub;
        if (!o[2])     r = p;
        else if (o[1]) r = hl - p;
        else           r = hl + p;
        return {32'(r >> w) & m[31:0], r[31:0] & m[31:0]};
    endfunction

    // MTHI/MTLO while idle, then read back
    task automatic mt(input logic h, input logic l, input logic [31:0] d);
        logic [31:0] msk;
        msk = sel ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        @(negedge clk);
        wr_hi = h; wr_lo = l; wdata = d;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        #1;
        if (h) m_hi[sel] = d & msk;
        if (l) m_lo[sel] = d & msk;
        chk("mt_hi", hi_cur, m_hi[sel]);
        chk("mt_lo", lo_cur, m_lo[sel]);
    endtask

    // Issue one op; ek: 0 none, 1 extra start, 2 wr_lo, 3 abort, applied in cycle ec
    task automatic run_op(input int ec, input int ek, input logic [2:0] o,
                          input logic [31:0] xa, input logic [31:0] xb);
        int          n;
        int          lat;
        logic [63:0] r;
        lat = lat_of(sel, o);
        @(negedge clk);
        op = o; a = xa; b = xb; start = 1'b1;
        #1;
        n = 0;
        while (busy_cur && n < 64) begin
            n++;
            @(negedge clk);
            start = 1'b0; abort = 1'b0; wr_lo = 1'b0;
            op = 3'($urandom); a = $urandom; b = $urandom;
            if (n == ec) begin
                if (ek == 1) start = 1'b1;
                else if (ek == 2) begin wr_lo = 1'b1; wdata = $urandom; end
                else if (ek == 3) abort = 1'b1;
            end
            #1;
        end
        start = 1'b0; abort = 1'b0; wr_lo = 1'b0;
        chk("busy_len", 64'(n), 64'((ek == 3) ? ec + 1 : lat + 1));
        if (ek != 3) begin
            r = ref_op(sel, o, xa, xb, m_hi[sel], m_lo[sel]);
            m_hi[sel] = r[63:32];
            m_lo[sel] = r[31:0];
        end
        chk("res_hi", hi_cur, m_hi[sel]);
        chk("res_lo", lo_cur, m_lo[sel]);
    endtask

    task automatic rand_phase(input logic s, input int cnt);
        logic [2:0]  o;
        logic [31:0] xa, xb;
        int          ek, ec;
        sel = s;
        for (int i = 0; i < cnt; i++) begin
            o = 3'($urandom); xa = $urandom; xb = $urandom; ek = 0; ec = 0;
            if ($urandom_range(0, 7) == 0) begin
                mt(1'($urandom), 1'($urandom), $urandom);
            end else begin
                if ($urandom_range(0, 5) == 0) xb = 32'd0;
                if ($urandom_range(0, 7) == 0) begin
                    o = 3'd2; xa = s ? 32'h8000 : 32'h8000_0000; xb = 32'hFFFF_FFFF;
                end
                if ($urandom_range(0, 4) == 0) begin
                    ek = $urandom_range(1, 3);
                    ec = $urandom_range(1, lat_of(s, o));
                end
                run_op(ec, ek, o, xa, xb);
            end
        end
    endtask

    typedef struct {
        logic        s;
        logic [2:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    } vec_t;

    vec_t tbl[16];

    initial begin
        //          s     op    a              b              pre_hi         pre_lo         exp_hi         exp_lo
        tbl[0]  = '{1'b0, 3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        tbl[1]  = '{1'b0, 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[2]  = '{1'b0, 3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 32'h0000_1234, 32'h0000_5678};
        tbl[3]  = '{1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 32'h8000_0000};
        tbl[4]  = '{1'b0, 3'd5, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0,         32'h1,         32'h0000_0001, 32'hFFFF_FFFF};
        tbl[5]  = '{1'b0, 3'd7, 32'hFFFF_FFFF, 32'h0000_0002, 32'h1,         32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        tbl[6]  = '{1'b0, 3'd6, 32'hFFFF_FFFF, 32'h0000_0002, 32'h1,         32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
        tbl[7]  = '{1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'hFFFF_FFFE, 32'h0000_0001};
        tbl[8]  = '{1'b0, 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        tbl[9]  = '{1'b0, 3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0,         32'h0,         32'h0000_0001, 32'hFFFF_FFFD};
        tbl[10] = '{1'b0, 3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0,         32'h0,         32'h0000_000F, 32'h0FFF_FFFF};
        tbl[11] = '{1'b0, 3'd7, 32'h0000_0001, 32'h0000_0001, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[12] = '{1'b1, 3'd0, 32'h0000_FFFD, 32'h0000_0005, 32'h0,         32'h0,         32'h0000_FFFF, 32'h0000_FFF1};
        tbl[13] = '{1'b1, 3'd2, 32'h0000_FFF9, 32'h0000_0002, 32'h0,         32'h0,         32'h0000_FFFF, 32'h0000_FFFD};
        tbl[14] = '{1'b1, 3'd2, 32'h0000_8000, 32'h0000_FFFF, 32'h5,         32'h6,         32'h0000_0000, 32'h0000_8000};
        tbl[15] = '{1'b1, 3'd5, 32'h0000_FFFF, 32'h0000_0002, 32'h0,         32'h1,         32'h0000_0001, 32'h0000_FFFF};

        for (int k = 0; k < 2; k++) begin m_hi[k] = '0; m_lo[k] = '0; end

        // Asynchronous reset before any clock edge
        #2 reset = 1'b0;
        #1;
        chk("rst_busy32", {63'b0, busy32}, 64'd0);
        chk("rst_hi32", hi32, 64'd0);
        chk("rst_lo32", lo32, 64'd0);
        chk("rst_busy16", {63'b0, busy16}, 64'd0);
        chk("rst_hi16", {48'b0, hi16}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors
        for (int t = 0; t < 16; t++) begin
            sel = tbl[t].s;
            mt(1'b1, 1'b0, tbl[t].pre_hi);
            mt(1'b0, 1'b1, tbl[t].pre_lo);
            run_op(0, 0, tbl[t].op, tbl[t].a, tbl[t].b);
            chk("tbl_hi", hi_cur, tbl[t].exp_hi);
            chk("tbl_lo", lo_cur, tbl[t].exp_lo);
        end

        // start with kill: not accepted, HI/LO untouched
        sel = 1'b0;
        mt(1'b1, 1'b1, 32'hCAFE_F00D);
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        #1 chk("kill_busy", {63'b0, busy32}, 64'd0);
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        #1;
        chk("kill_busy_after", {63'b0, busy32}, 64'd0);
        chk("kill_hi", hi32, 32'hCAFE_F00D);
        chk("kill_lo", lo32, 32'hCAFE_F00D);

        // Abort at cycle 3 of MULT, then a normal op; abort on the commit edge
        run_op(3, 3, 3'd0, 32'd1234, 32'd77);
        run_op(0, 0, 3'd1, 32'd1234, 32'd77);
        run_op(5, 3, 3'd0, 32'd9, 32'd9);
        // start while busy, and MTLO while busy, are both ignored
        run_op(2, 1, 3'd0, 32'hFFFF_0000, 32'h0001_0001);
        run_op(4, 2, 3'd3, 32'd1000, 32'd33);

        // Asynchronous reset in the middle of a DIV
        mt(1'b1, 1'b1, 32'hA5A5_5A5A);
        @(negedge clk);
        op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 chk("div_busy_pre", {63'b0, busy32}, 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {63'b0, busy32}, 64'd0);
        chk("mid_rst_hi", hi32, 64'd0);
        chk("mid_rst_lo", lo32, 64'd0);
        chk("mid_rst_lo16", {48'b0, lo16}, 64'd0);
        for (int k = 0; k < 2; k++) begin m_hi[k] = '0; m_lo[k] = '0; end
        @(negedge clk);
        reset = 1'b1;

        // Randomised ops against the reference model, both widths
        rand_phase(1'b0, 60);
        rand_phase(1'b1, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
